// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch: 32x32 register file with write-back bypass,
// operand B mux, and a single-entry pipeline register driving the ALU.
module operand_fetch_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [3:0]      in_opsel,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      Opsel,
  output logic [AW-1:0]   out_rd
);

  logic [XLEN-1:0] r_rf [NREG];

  logic            r_vld_p1;
  logic [XLEN-1:0] r_a_p1;
  logic [XLEN-1:0] r_b_p1;
  logic [3:0]      r_opsel_p1;
  logic [AW-1:0]   r_rd_p1;
  logic [AW-1:0]   r_rs1_p1;
  logic [AW-1:0]   r_rs2_p1;
  logic            r_use_imm_p1;

  logic            w_wb_hit;
  logic            w_accept;
  logic [XLEN-1:0] w_rs1_val_p0;
  logic [XLEN-1:0] w_rs2_val_p0;
  logic [XLEN-1:0] w_b_sel_p0;

  // x0 reads as zero; a write landing this cycle on the same index wins over the array.
  function automatic logic [XLEN-1:0] read_bypass(
    input logic [AW-1:0]   idx,
    input logic [XLEN-1:0] arr_val,
    input logic            we,
    input logic [AW-1:0]   wrd,
    input logic [XLEN-1:0] wdata
  );
    logic [XLEN-1:0] v;
    if (idx == '0)
      v = '0;
    else if (we && (wrd == idx))
      v = wdata;
    else
      v = arr_val;
    return v;
  endfunction

  assign w_wb_hit     = wb_en && (wb_rd != '0);
  assign w_rs1_val_p0 = read_bypass(in_rs1, r_rf[in_rs1], wb_en, wb_rd, wb_data);
  assign w_rs2_val_p0 = read_bypass(in_rs2, r_rf[in_rs2], wb_en, wb_rd, wb_data);
  assign w_b_sel_p0   = in_use_imm ? in_imm : w_rs2_val_p0;

  assign in_ready = !flush && (!r_vld_p1 || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_rf[i] <= '0;
    end else if (w_wb_hit) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // ---- p0 -> p1: operand capture, drain, and in-place refresh while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_a_p1       <= '0;
      r_b_p1       <= '0;
      r_opsel_p1   <= 4'b0000;
      r_rd_p1      <= '0;
      r_rs1_p1     <= '0;
      r_rs2_p1     <= '0;
      r_use_imm_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1     <= 1'b1;
      r_a_p1       <= w_rs1_val_p0;
      r_b_p1       <= w_b_sel_p0;
      r_opsel_p1   <= in_opsel;
      r_rd_p1      <= in_rd;
      r_rs1_p1     <= in_rs1;
      r_rs2_p1     <= in_rs2;
      r_use_imm_p1 <= in_use_imm;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end else if (r_vld_p1 && w_wb_hit) begin
      if (wb_rd == r_rs1_p1)
        r_a_p1 <= wb_data;
      if (!r_use_imm_p1 && (wb_rd == r_rs2_p1))
        r_b_p1 <= wb_data;
    end
  end

  assign out_valid = r_vld_p1;
  assign A         = r_a_p1;
  assign B         = r_b_p1;
  assign Opsel     = r_opsel_p1;
  assign out_rd    = r_rd_p1;

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute stage of the RISC-V core. It holds the 32x32 integer register file, reads the two source operands for each decoded instruction, and selects register or immediate for operand B. It registers A, B and Opsel into a single-entry pipeline register that drives the ALU directly. It accepts write-back from downstream, with same-cycle bypass and in-place operand refresh while the stage is stalled.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers (x0 hardwired to zero)
- AW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_rs1, in_rs2  in  AW  source register indices
- in_rd  in  AW  destination index, passed through
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  1: B = in_imm, 0: B = rs2 value
- in_opsel  in  4  ALU operation select, passed through
- wb_en  in  1  write-back strobe
- wb_rd  in  AW  write-back index
- wb_data  in  XLEN  write-back value
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  A/B/Opsel valid for ALU
- out_ready  in  1  execute stage consumes this cycle
- A, B  out  XLEN  ALU operands
- Opsel  out  4  ALU operation select
- out_rd  out  AW  destination index to execute stage

## Operation
- Register file:
  - Reads are combinational.
  - Writes occur at the rising edge when wb_en=1 and wb_rd!=0. Writes to x0 are dropped, and x0 always reads 0.
- Bypass: when wb_en=1 and wb_rd==rsN!=0 in the same cycle, the read of rsN returns wb_data, not the array contents.
- Pipeline register:
  - State is EMPTY (out_valid=0) or FULL (out_valid=1).
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
- On accept:
  - A ← bypassed rf[rs1].
  - B ← in_use_imm ? in_imm : bypassed rf[rs2].
  - Opsel, out_rd, and internal copies of rs1, rs2 and use_imm are loaded.
  - out_valid ← 1.
- FULL and out_ready=1 with no accept: out_valid ← 0. A/B/Opsel hold their last values.
- Stall refresh: when FULL, out_ready=0 and wb_en=1 with wb_rd!=0:
  - If wb_rd==held rs1, A ← wb_data.
  - If !held use_imm and wb_rd==held rs2, B ← wb_data.
  - If both sources equal wb_rd, both are updated.
- Flush: has priority over everything. out_valid ← 0 at the next edge, and no accept occurs. Register file writes still happen.
- Write-back is independent of the handshake and never stalls.

## Timing
- Reset (asynchronous):
  - All 32 registers clear to 0.
  - out_valid=0; A, B, out_rd = 0; Opsel=4'b0000.
  - in_ready=1 once flush=0.
  - Reset asserted mid-stall drops the held instruction.
- Latency: accept at edge N → out_valid=1 with operands from edge N. The ALU result is usable in cycle N+1.
- Throughput: one instruction per cycle while out_ready=1.
- Write at edge N: a read in cycle N sees the value via bypass; reads in cycle N+1 onward see it from the array.
- out_valid and operands are stable while out_valid=1 && out_ready=0, except for stall-refresh updates.
- Simultaneous write-back and accept to the same source register: the captured operand equals wb_data.
- Simultaneous flush and in_valid: the instruction is not accepted (in_ready=0), and the upstream stage must re-present it or discard it.

## Test plan
- Reset, then write x5=22, x6=32 via wb. Present rs1=5, rs2=6, opsel=0000 → next cycle out_valid=1, A=22, B=32, Opsel=0000.
- Same-cycle bypass: wb_en=1, wb_rd=7, wb_data=0xDEADBEEF while accepting rs1=7 → A=0xDEADBEEF. Writing x0=0x55 and then reading rs1=0 → A=0.
- Immediate path: rs2=6 (x6=32), in_use_imm=1, in_imm=0xFFFFFFF0 → B=0xFFFFFFF0.
- Stall refresh: FULL with rs1=rs2=9, out_ready=0. Write x9=0x1234 → A=B=0x1234 while out_valid stays 1 and in_ready=0. Raise out_ready → handoff, then a fresh accept the next cycle.
- Flush mid-stall with in_valid=1 → out_valid=0 next cycle and the incoming instruction is not captured. Assert rst asynchronously while FULL → out_valid, A and B go 0 immediately, and x5 reads 0.
- Back-to-back stream of 16 instructions cycling Opsel 0000..1111 with out_ready=1 → one out_valid per cycle with matching Opsel order, and no bubbles.
